// File: rtl/bcd_pkg.sv
// Shared BCD constants, digit type and a validity helper used by the counter
// datapath and its per-digit step logic.
package bcd_pkg;

  localparam int BCD_W = 4;

  typedef logic [BCD_W-1:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

  function automatic logic bcd_is_valid(input bcd_digit_t d);
    return (d <= BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_counter_if.sv
// Control/data bundle of the BCD counter: the master drives the controls and
// the load value, the slave (the counter) returns the count and two pulses.
interface bcd_counter_if #(
  parameter int DIGITS = 4
) ();

  logic                clear;
  logic                load;
  logic [4*DIGITS-1:0] load_val;
  logic                en;
  logic                up;
  logic [4*DIGITS-1:0] count;
  logic                carry;
  logic                load_err;

  // No valid/ready handshake: every control is sampled on each rising clock
  // edge and all outputs are registered, changing one edge after the inputs.
  modport master (
    output clear, load, load_val, en, up,
    input  count, carry, load_err
  );

  modport slave (
    input  clear, load, load_val, en, up,
    output count, carry, load_err
  );

endinterface

// File: rtl/bcd_digit.sv
// Combinational next value of one BCD digit; step_i/step_o form the ripple
// carry (counting up) or borrow (counting down) chain between digits.
module bcd_digit
  import bcd_pkg::*;
(
  input  bcd_digit_t digit_i,
  input  logic       up_i,
  input  logic       step_i,
  output bcd_digit_t digit_o,
  output logic       step_o
);

  always_comb begin
    digit_o = digit_i;
    step_o  = 1'b0;
    if (!bcd_is_valid(digit_i)) begin
      // Unreachable in stored state; forced back into range without a step.
      digit_o = BCD_MIN;
    end else if (step_i) begin
      if (up_i) begin
        if (digit_i == BCD_MAX) begin
          digit_o = BCD_MIN;
          step_o  = 1'b1;
        end else begin
          digit_o = digit_i + 4'd1;
        end
      end else begin
        if (digit_i == BCD_MIN) begin
          digit_o = BCD_MAX;
          step_o  = 1'b1;
        end else begin
          digit_o = digit_i - 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/bcd_counter.sv
// Multi-digit registered BCD up/down counter with synchronous clear, sanitised
// parallel load, and one-cycle wrap (carry) and bad-load (load_err) pulses.
module bcd_counter
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  bcd_counter_if.slave  bus
);

  localparam int W = BCD_W * DIGITS;

  logic [W-1:0]      count_q, count_d;
  logic [W-1:0]      step_val;
  logic [W-1:0]      load_clean;
  logic [DIGITS:0]   step;
  logic [DIGITS-1:0] load_bad;
  logic              carry_q, carry_d;
  logic              load_err_q, load_err_d;

  // Digit 0 always steps; the enable is applied at the register.
  assign step[0] = 1'b1;

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_digit
      bcd_digit u_digit (
        .digit_i (count_q[g*BCD_W +: BCD_W]),
        .up_i    (bus.up),
        .step_i  (step[g]),
        .digit_o (step_val[g*BCD_W +: BCD_W]),
        .step_o  (step[g+1])
      );

      assign load_bad[g] = !bcd_is_valid(bus.load_val[g*BCD_W +: BCD_W]);
      assign load_clean[g*BCD_W +: BCD_W] =
        load_bad[g] ? BCD_MIN : bus.load_val[g*BCD_W +: BCD_W];
    end
  endgenerate

  always_comb begin
    count_d    = count_q;
    carry_d    = 1'b0;
    load_err_d = 1'b0;
    if (bus.clear) begin
      count_d = '0;
    end else if (bus.load) begin
      count_d    = load_clean;
      load_err_d = |load_bad;
    end else if (bus.en) begin
      count_d = step_val;
      carry_d = step[DIGITS];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q    <= '0;
      carry_q    <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      carry_q    <= carry_d;
      load_err_q <= load_err_d;
    end
  end

  assign bus.count    = count_q;
  assign bus.carry    = carry_q;
  assign bus.load_err = load_err_q;

endmodule

// File: tb/tb_bcd_counter.sv
// Directed-vector bench for a 4-digit bcd_counter: reset, ripple, wrap,
// invalid load, priority and asynchronous reset mid-count.
module tb_bcd_counter;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic clk;
  logic reset_n;

  int n_vec;
  int n_err;

  logic [W-1:0] exp_q[$];

  bcd_counter_if #(.DIGITS(DIGITS)) bus ();

  bcd_counter #(.DIGITS(DIGITS)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one set of controls at the falling edge, then return 1 ns after the
  // following rising edge so outputs can be sampled away from the edge.
  task automatic apply(input logic clr, input logic ld, input logic [W-1:0] lv,
                       input logic e, input logic u);
    @(negedge clk);
    bus.clear    = clr;
    bus.load     = ld;
    bus.load_val = lv;
    bus.en       = e;
    bus.up       = u;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [W-1:0] cnt,
                            input logic cy, input logic le);
    check({tag, ".count"},    32'(bus.count), 32'(cnt));
    check({tag, ".carry"},    32'(bus.carry), 32'(cy));
    check({tag, ".load_err"}, 32'(bus.load_err), 32'(le));
  endtask

  initial begin
    logic [W-1:0] exp_cnt;
    n_vec        = 0;
    n_err        = 0;
    reset_n      = 1'b0;
    bus.clear    = 1'b0;
    bus.load     = 1'b0;
    bus.load_val = '0;
    bus.en       = 1'b1;
    bus.up       = 1'b1;

    // Reset held with en=1: outputs stay zero across edges.
    #1;
    expect_out("rst0", 16'h0000, 1'b0, 1'b0);
    repeat (3) apply(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    expect_out("rst_hold", 16'h0000, 1'b0, 1'b0);

    @(negedge clk);
    reset_n = 1'b1;
    bus.en  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      apply(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
      check("idle.count", 32'(bus.count), 32'h0000);
    end

    // Up ripple and wrap via the expected queue.
    apply(1'b0, 1'b1, 16'h9998, 1'b0, 1'b1);
    expect_out("ld9998", 16'h9998, 1'b0, 1'b0);
    exp_q.push_back(16'h9999);
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0001);
    for (int i = 0; i < 3; i++) begin
      apply(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
      exp_cnt = exp_q.pop_front();
      expect_out("up_wrap", exp_cnt, (i == 1), 1'b0);
    end

    // Ripple through three nines into the top digit.
    apply(1'b0, 1'b1, 16'h0999, 1'b0, 1'b1);
    apply(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    expect_out("up_ripple", 16'h1000, 1'b0, 1'b0);

    // Down borrow and wrap.
    apply(1'b0, 1'b1, 16'h0100, 1'b0, 1'b0);
    apply(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    expect_out("dn_borrow", 16'h0099, 1'b0, 1'b0);
    apply(1'b0, 1'b1, 16'h0001, 1'b0, 1'b0);
    apply(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    expect_out("dn_zero", 16'h0000, 1'b0, 1'b0);
    apply(1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    expect_out("dn_wrap", 16'h9999, 1'b1, 1'b0);
    apply(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    expect_out("dn_hold", 16'h9999, 1'b0, 1'b0);

    // Invalid load digits replaced by zero.
    apply(1'b0, 1'b1, 16'h3A7F, 1'b0, 1'b1);
    expect_out("ld_bad", 16'h3070, 1'b0, 1'b1);
    apply(1'b0, 1'b0, 16'h0000, 1'b0, 1'b1);
    expect_out("ld_bad_hold", 16'h3070, 1'b0, 1'b0);
    apply(1'b0, 1'b1, 16'h1234, 1'b0, 1'b1);
    expect_out("ld_good", 16'h1234, 1'b0, 1'b0);

    // Priority: clear over load over en.
    apply(1'b0, 1'b1, 16'h5555, 1'b0, 1'b1);
    expect_out("ld5555", 16'h5555, 1'b0, 1'b0);
    apply(1'b1, 1'b1, 16'hFFFF, 1'b1, 1'b1);
    expect_out("prio_clr", 16'h0000, 1'b0, 1'b0);
    apply(1'b0, 1'b1, 16'h9999, 1'b1, 1'b1);
    expect_out("prio_ld", 16'h9999, 1'b0, 1'b0);
    apply(1'b0, 1'b1, 16'h9999, 1'b1, 1'b1);
    expect_out("prio_ld_nowrap", 16'h9999, 1'b0, 1'b0);

    // Asynchronous reset between edges while counting.
    apply(1'b0, 1'b1, 16'h0426, 1'b0, 1'b1);
    apply(1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
    expect_out("pre_rst", 16'h0427, 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    expect_out("async_rst", 16'h0000, 1'b0, 1'b0);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    expect_out("resume", 16'h0001, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
